// File: rtl/ksa_nibble_sequencer_if.sv
// Bundles the operand request, adder-facing nibble bus and result handshake
// of the nibble sequencer. The sequencer connects through the slave modport.
interface ksa_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/ksa_nibble_sequencer.sv
// Serialises a WIDTH-bit addition onto an external 4-bit combinational adder,
// one nibble per cycle LSB first, and returns the result over valid/ready.
module ksa_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ksa_nibble_sequencer_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];
    logic       run;
    logic       done;
    logic       last;

    assign run  = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign last = (idx_q == IDXW'(NIB - 1));

    // Only the nibble selected by the index captures the adder sum; the
    // others keep their value, so the result assembles in place.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_q[gi*4 +: 4];
            assign b_nib[gi] = b_q[gi*4 +: 4];
            assign res_d[gi*4 +: 4] = (run && (idx_q == IDXW'(gi))) ? bus.add_s
                                                                   : res_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = bus.add_cout;
                idx_d   = last ? '0 : idx_q + IDXW'(1);
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are gated by state so partial results never leak out.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.add_a     = run ? a_nib[idx_q] : 4'd0;
    assign bus.add_b     = run ? b_nib[idx_q] : 4'd0;
    assign bus.add_cin   = run & carry_q;
    assign bus.out_valid = done;
    assign bus.out_sum   = done ? res_q : '0;
    assign bus.out_cout  = done & carry_q;
    assign bus.out_ovf   = done & (a_q[WIDTH-1] == b_q[WIDTH-1])
                                & (res_q[WIDTH-1] != a_q[WIDTH-1]);
    assign bus.busy      = run | done;
endmodule

// File: tb/tb_ksa_nibble_sequencer.sv
// Bench for ksa_nibble_sequencer: behavioural 4-bit adder on the nibble bus,
// directed and random operations checked against a whole-word reference sum.
module tb_ksa_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ksa_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    ksa_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

    // {ovf, cout, sum}
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic cin);
        logic [WIDTH:0] full;
        logic           ovf;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full};
    endfunction

    // carry entering nibble k of the word-level sum
    function automatic logic [NIB-1:0] ref_carries(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic cin);
        logic [NIB-1:0] c;
        longint unsigned m, s;
        for (int k = 0; k < NIB; k++) begin
            m = (64'd1 << (4 * k)) - 64'd1;
            s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
            c[k] = ((s >> (4 * k)) & 64'd1) != 0;
        end
        return c;
    endfunction

    task automatic randomize_inputs();
        bus.in_a   = WIDTH'($urandom);
        bus.in_b   = WIDTH'($urandom);
        bus.in_cin = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         output logic [WIDTH-1:0] sum, output logic cout, output logic ovf,
                         output int lat, output logic [NIB-1:0] cin_seq);
        int n;
        @(negedge clk);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        randomize_inputs();
        lat     = 0;
        cin_seq = '0;
        while (!bus.out_valid && lat < 4 * NIB + 8) begin
            if (lat < NIB) cin_seq[lat] = bus.add_cin;
            @(negedge clk);
            lat++;
        end
        sum  = bus.out_sum;
        cout = bus.out_cout;
        ovf  = bus.out_ovf;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'hBEEF;
        bus.in_b      = 16'h1234;
        bus.in_cin    = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b required 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b ovf=%b required 0/0/0",
                     bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'd0) begin
            errors++;
            $display("FAIL reset_adder: add_a=%h add_b=%h add_cin=%b required 0/0/0",
                     bus.add_a, bus.add_b, bus.add_cin);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_carry_chain();
        logic [WIDTH-1:0] sum; logic cout, ovf; int lat; logic [NIB-1:0] cs;
        do_op(16'hFFFF, 16'h0001, 1'b0, sum, cout, ovf, lat, cs);
        checks++;
        if ({ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL carry_chain: ovf=%b cout=%b sum=%h required 0 1 0000", ovf, cout, sum);
        end
        checks++;
        if (lat !== NIB) begin
            errors++;
            $display("FAIL carry_chain_latency: %0d edges required %0d", lat, NIB);
        end
        checks++;
        if (cs !== 4'b1110) begin
            errors++;
            $display("FAIL carry_chain_add_cin: seq=%b required 1110", cs);
        end
        $display("op FFFF+0001+0 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, lat);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] sum; logic cout, ovf; int lat; logic [NIB-1:0] cs;
        do_op(16'h7FFF, 16'h0001, 1'b0, sum, cout, ovf, lat, cs);
        checks++;
        if ({ovf, cout, sum} !== {1'b1, 1'b0, 16'h8000}) begin
            errors++;
            $display("FAIL overflow: ovf=%b cout=%b sum=%h required 1 0 8000", ovf, cout, sum);
        end
        $display("op 7FFF+0001+0 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, lat);
    endtask

    task automatic test_carry_in();
        logic [WIDTH-1:0] sum; logic cout, ovf; int lat; logic [NIB-1:0] cs;
        do_op(16'h1234, 16'h4321, 1'b1, sum, cout, ovf, lat, cs);
        checks++;
        if ({cout, sum} !== {1'b0, 16'h5556}) begin
            errors++;
            $display("FAIL carry_in: cout=%b sum=%h required 0 5556", cout, sum);
        end
        checks++;
        if (cs !== 4'b0001) begin
            errors++;
            $display("FAIL carry_in_add_cin: seq=%b required 0001", cs);
        end
        $display("op 1234+4321+1 -> sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, lat);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b; logic cin; logic [WIDTH+1:0] exp; int n;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom_range(0, 1));
        exp = ref_add(a, b, cin);
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        // keep in_valid high with new operands: must be ignored until IDLE
        randomize_inputs();
        n = 0;
        while (!bus.out_valid && n < 4 * NIB + 8) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_ovf, bus.out_cout, bus.out_sum} !== {1'b1, exp}
                || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ovf=%b cout=%b sum=%h in_ready=%b required 1 %b %b %h 0",
                         i, bus.out_valid, bus.out_ovf, bus.out_cout, bus.out_sum, bus.in_ready,
                         exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_release: valid/in_ready/busy=%b required 010",
                     {bus.out_valid, bus.in_ready, bus.busy});
        end
        $display("op %h+%h+%b held 3 cycles -> sum=%h", a, b, cin, exp[WIDTH-1:0]);
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] sum; logic cout, ovf; int lat; logic [NIB-1:0] cs; logic seen;
        @(negedge clk);
        bus.in_a = 16'hAAAA; bus.in_b = 16'h5555; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_run: valid/in_ready/busy=%b required 010",
                     {bus.out_valid, bus.in_ready, bus.busy});
        end
        seen = 1'b0;
        repeat (NIB + 2) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run_no_pulse: out_valid seen=%b required 0", seen);
        end
        do_op(16'h0001, 16'h0001, 1'b0, sum, cout, ovf, lat, cs);
        checks++;
        if ({ovf, cout, sum, lat} !== {1'b0, 1'b0, 16'h0002, NIB}) begin
            errors++;
            $display("FAIL reset_mid_run_next: ovf=%b cout=%b sum=%h lat=%0d required 0 0 0002 %0d",
                     ovf, cout, sum, lat, NIB);
        end
        $display("op 0001+0001+0 after abort -> sum=%h lat=%0d", sum, lat);
    endtask

    task automatic test_back_to_back();
        logic [2*WIDTH:0] q[$];
        logic [2*WIDTH:0] ent;
        logic [WIDTH+1:0] exp;
        logic             pushed;
        int               got, last_cyc;
        got = 0; last_cyc = -1; pushed = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        randomize_inputs();
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            if (pushed) randomize_inputs();
            pushed = 1'b0;
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_duplicate: result %h with no pending op", bus.out_sum);
                end else begin
                    ent = q.pop_front();
                    exp = ref_add(ent[2*WIDTH:WIDTH+1], ent[WIDTH:1], ent[0]);
                    if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: ovf=%b cout=%b sum=%h required %b %b %h", got,
                                 bus.out_ovf, bus.out_cout, bus.out_sum,
                                 exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
                    end
                    $display("b2b %h+%h+%b -> sum=%h", ent[2*WIDTH:WIDTH+1], ent[WIDTH:1], ent[0],
                             bus.out_sum);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != NIB + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: %0d cycles required %0d", cyc - last_cyc, NIB + 2);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (bus.in_ready) begin
                q.push_back({bus.in_a, bus.in_b, bus.in_cin});
                pushed = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL b2b_count: %0d results required 10", got);
        end
        bus.in_valid = 1'b0;
        repeat (NIB + 4) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_carry_chain();
        test_overflow();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
